// File: rtl/bcd_display_scan.sv
// Captures a 3-digit BCD sum plus carry and scans it onto a multiplexed 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (units digit always shown).
module bcd_display_scan #(
  parameter int PRESCALE   = 50000,
  parameter bit SEG_ACT_LO = 1'b0,
  parameter bit AN_ACT_LO  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] s,
  input  logic        cout,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        err
);

  localparam int               PRE_W   = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [6:0]       SEG_OFF = SEG_ACT_LO ? 7'h7F : 7'h00;
  localparam logic [3:0]       AN_OFF  = AN_ACT_LO ? 4'hF : 4'h0;

  logic [12:0]      val_q, val_d;
  logic             err_q, err_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic [2:0] nib_big;
  logic [3:0] digit;
  logic       blank;
  logic [6:0] seg_code;

  for (genvar gi = 0; gi < 3; gi++) begin : g_nib
    assign nib_big[gi] = (s[gi*4 +: 4] > 4'd9);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      err_q <= 1'b0;
      pre_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      val_q <= val_d;
      err_q <= err_d;
      pre_q <= pre_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  always_comb begin
    val_d = val_q;
    err_d = err_q;
    if (load) begin
      val_d = {cout, s};
      err_d = |nib_big;
    end
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_MAX) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Blanking only chains through zero digits, so an "E" digit (non-zero) naturally stops it.
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd0:    digit = val_q[3:0];
      2'd1:    digit = val_q[7:4];
      2'd2:    digit = val_q[11:8];
      default: digit = {3'b000, val_q[12]};
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd3:    blank = ~val_q[12];
      2'd2:    blank = ~val_q[12] && (val_q[11:8] == 4'd0);
      2'd1:    blank = ~val_q[12] && (val_q[11:8] == 4'd0) && (val_q[7:4] == 4'd0);
      default: blank = 1'b0;
    endcase
`endif
  end

  always_comb begin
    case (digit)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h79;
    endcase
  end

  always_comb begin
    seg_d = blank ? 7'h00 : seg_code;
    if (SEG_ACT_LO) seg_d = ~seg_d;
    an_d = 4'b0001 << idx_q;
    if (AN_ACT_LO) an_d = ~an_d;
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan: per-cycle scoreboard against a behavioural model,
// plus a vector table of captured values with the expected segment code for each slot.
module tb_bcd_display_scan;

  localparam int PRESCALE = 4;
  localparam int NV = 8;

  logic        clk = 1'b0;
  logic        rst, load, cout;
  logic [11:0] s;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        err;

  always #5 clk = ~clk;

  bcd_display_scan #(
    .PRESCALE  (PRESCALE),
    .SEG_ACT_LO(1'b0),
    .AN_ACT_LO (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .load(load),
    .s   (s),
    .cout(cout),
    .seg (seg),
    .an  (an),
    .err (err)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       err;
  } obs_t;

  typedef struct packed {
    logic [11:0]     s;
    logic            cout;
    logic            err;
    logic [3:0][6:0] slot_seg;
  } vec_t;

  obs_t  sb_q[$];
  vec_t  tbl[NV];
  int    vec_cnt = 0;
  int    miss_cnt = 0;

  logic [12:0] m_val;
  logic        m_err;
  int          m_pre, m_idx;

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h79;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int idx, input logic [12:0] v);
    logic [3:0] d;
    logic       blank;
    blank = 1'b0;
    case (idx)
      0: d = v[3:0];
      1: d = v[7:4];
      2: d = v[11:8];
      default: d = {3'b000, v[12]};
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 3)      blank = !v[12];
    else if (idx == 2) blank = !v[12] && (v[11:8] == 4'd0);
    else if (idx == 1) blank = !v[12] && (v[11:8] == 4'd0) && (v[7:4] == 4'd0);
`endif
    return blank ? 7'h00 : seg_lut(d);
  endfunction

  function automatic int slot_of(input logic [3:0] a);
    case (a)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vec_cnt++;
    if (act !== exp_v) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // One clock: advance the model on the edge, queue its prediction, then compare after the edge.
  task automatic cyc();
    obs_t e, o;
    @(posedge clk);
    if (rst) begin
      e     = '0;
      m_val = '0;
      m_err = 1'b0;
      m_pre = 0;
      m_idx = 0;
    end else begin
      e.an  = 4'b0001 << m_idx;
      e.seg = model_seg(m_idx, m_val);
      if (load) begin
        m_val = {cout, s};
        m_err = (s[3:0] > 4'd9) || (s[7:4] > 4'd9) || (s[11:8] > 4'd9);
      end
      e.err = m_err;
      if (m_pre == PRESCALE - 1) begin
        m_pre = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_pre++;
      end
    end
    sb_q.push_back(e);
    #1;
    o = sb_q.pop_front();
    check("sb_an", 32'(an), 32'(o.an));
    check("sb_seg", 32'(seg), 32'(o.seg));
    check("sb_err", 32'(err), 32'(o.err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][6:0] seg321;
    int cnt[4];
    int k, k0, k1;

`ifdef LEADING_ZERO_BLANK_EN
    tbl[0] = '{s: 12'h987, cout: 1'b1, err: 1'b0, slot_seg: {7'h06, 7'h6F, 7'h7F, 7'h07}};
    tbl[1] = '{s: 12'h0A5, cout: 1'b0, err: 1'b1, slot_seg: {7'h00, 7'h00, 7'h79, 7'h6D}};
    tbl[2] = '{s: 12'h005, cout: 1'b0, err: 1'b0, slot_seg: {7'h00, 7'h00, 7'h00, 7'h6D}};
    tbl[3] = '{s: 12'h234, cout: 1'b1, err: 1'b0, slot_seg: {7'h06, 7'h5B, 7'h4F, 7'h66}};
    tbl[4] = '{s: 12'hF6C, cout: 1'b0, err: 1'b1, slot_seg: {7'h00, 7'h79, 7'h7D, 7'h79}};
    tbl[5] = '{s: 12'h000, cout: 1'b0, err: 1'b0, slot_seg: {7'h00, 7'h00, 7'h00, 7'h3F}};
    tbl[6] = '{s: 12'h007, cout: 1'b0, err: 1'b0, slot_seg: {7'h00, 7'h00, 7'h00, 7'h07}};
    tbl[7] = '{s: 12'h100, cout: 1'b0, err: 1'b0, slot_seg: {7'h00, 7'h06, 7'h3F, 7'h3F}};
`else
    tbl[0] = '{s: 12'h987, cout: 1'b1, err: 1'b0, slot_seg: {7'h06, 7'h6F, 7'h7F, 7'h07}};
    tbl[1] = '{s: 12'h0A5, cout: 1'b0, err: 1'b1, slot_seg: {7'h3F, 7'h3F, 7'h79, 7'h6D}};
    tbl[2] = '{s: 12'h005, cout: 1'b0, err: 1'b0, slot_seg: {7'h3F, 7'h3F, 7'h3F, 7'h6D}};
    tbl[3] = '{s: 12'h234, cout: 1'b1, err: 1'b0, slot_seg: {7'h06, 7'h5B, 7'h4F, 7'h66}};
    tbl[4] = '{s: 12'hF6C, cout: 1'b0, err: 1'b1, slot_seg: {7'h3F, 7'h79, 7'h7D, 7'h79}};
    tbl[5] = '{s: 12'h000, cout: 1'b0, err: 1'b0, slot_seg: {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    tbl[6] = '{s: 12'h007, cout: 1'b0, err: 1'b0, slot_seg: {7'h3F, 7'h3F, 7'h3F, 7'h07}};
    tbl[7] = '{s: 12'h100, cout: 1'b0, err: 1'b0, slot_seg: {7'h3F, 7'h06, 7'h3F, 7'h3F}};
`endif
    seg321 = {7'h06, 7'h4F, 7'h5B, 7'h06};

    // Reset held for two cycles, then the first slot appears one cycle after release.
    rst = 1'b1; load = 1'b0; s = 12'h000; cout = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("rst_an", 32'(an), 32'h0);
      check("rst_seg", 32'(seg), 32'h00);
      check("rst_err", 32'(err), 32'h0);
    end
    rst = 1'b0;
    cyc();
    check("rel_an", 32'(an), 32'h1);
    check("rel_seg", 32'(seg), 32'h3F);
    check("rel_err", 32'(err), 32'h0);
    for (int i = 0; i < 5; i++) cyc();

    // Vector table: one load pulse, then a full 16-cycle scan compared slot by slot.
    for (int i = 0; i < NV; i++) begin
      load = 1'b1; s = tbl[i].s; cout = tbl[i].cout;
      cyc();
      load = 1'b0;
      check($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].err));
      for (int j = 0; j < 4; j++) cnt[j] = 0;
      for (int c = 0; c < 4 * PRESCALE; c++) begin
        cyc();
        k = slot_of(an);
        check($sformatf("v%0d_onehot", i), 32'(k >= 0), 32'h1);
        if (k >= 0) begin
          check($sformatf("v%0d_slot%0d_seg", i, k), 32'(seg), 32'(tbl[i].slot_seg[k]));
          check($sformatf("v%0d_err_hold", i), 32'(err), 32'(tbl[i].err));
          cnt[k]++;
        end
      end
      for (int j = 0; j < 4; j++)
        check($sformatf("v%0d_slot%0d_cycles", i, j), 32'(cnt[j]), 32'(PRESCALE));
    end

    // Load held high tracks the input every cycle.
    for (int j = 1; j < 5; j++) begin
      load = 1'b1; s = 12'h111 * 12'(j); cout = j[0];
      cyc();
    end
    load = 1'b0;
    for (int i = 0; i < 8; i++) cyc();

    // Load on the same edge as the slot advance.
    for (int g = 0; g < 8 && m_pre != PRESCALE - 1; g++) cyc();
    k0 = m_idx;
    k1 = (m_idx + 1) % 4;
    load = 1'b1; s = 12'h321; cout = 1'b1;
    cyc();
    load = 1'b0;
    check("t5_an_old", 32'(an), 32'(4'b0001 << k0));
    cyc();
    check("t5_an_next", 32'(an), 32'(4'b0001 << k1));
    check("t5_seg_new", 32'(seg), 32'(seg321[k1]));
    for (int i = 0; i < 12; i++) cyc();

    // Reset in the middle of the hundreds slot.
    for (int g = 0; g < 20 && !(m_idx == 2 && m_pre == 2); g++) cyc();
    rst = 1'b1;
    cyc();
    check("t6_rst_an", 32'(an), 32'h0);
    check("t6_rst_seg", 32'(seg), 32'h00);
    rst = 1'b0;
    for (int i = 0; i < PRESCALE; i++) begin
      cyc();
      check("t6_an0", 32'(an), 32'h1);
      check("t6_seg0", 32'(seg), 32'h3F);
    end
    cyc();
    check("t6_an1", 32'(an), 32'h2);
    for (int i = 0; i < 8; i++) cyc();

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
